// File: rtl/pwm_dac_bank_if.sv
// Duty-write port of the PWM DAC bank: valid/ready write of one channel's on-time.
interface pwm_dac_bank_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned CH = 4
);
  localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1;

  logic           duty_valid;
  logic [CHW-1:0] duty_ch;
  logic [N-1:0]   duty_data;
  logic           duty_ready;

  modport master (output duty_valid, duty_ch, duty_data, input duty_ready);
  modport slave  (input duty_valid, duty_ch, duty_data, output duty_ready);
endinterface

// File: rtl/pwm_dac_bank.sv
// Multi-channel double-buffered PWM DAC bank.
// One free-running N-bit period counter feeds CH comparators; duty writes land in
// shadow registers and are committed to the active registers at the period wrap.
// Optional feature macro: PWM_DAC_PHASE_STAGGER_EN spreads channel phases evenly
// over the period (c_k = ctr + k*2^N/CH); undefined means all channels use ctr.
module pwm_dac_bank #(
  parameter int unsigned N  = 8,
  parameter int unsigned CH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  pwm_dac_bank_if.slave duty,
  output logic [CH-1:0] pwm_out,
  output logic          period_start
);
  localparam logic [N-1:0] CTR_MAX = {N{1'b1}};

  logic [N-1:0]  ctr_q, ctr_d;
  logic [N-1:0]  sh_q  [CH];
  logic [N-1:0]  sh_d  [CH];
  logic [N-1:0]  act_q [CH];
  logic [N-1:0]  act_d [CH];
  logic [N-1:0]  cmp_c [CH];
  logic [CH-1:0] pwm_q, pwm_d;
  logic          ps_q, ps_d;
  logic          wrap_c;
  logic          write_c;
  logic          duty_ready_c;

  // Wrap cycle: commit point; writes are stalled so none is lost at commit.
  assign wrap_c       = enable && (ctr_q == CTR_MAX);
  assign duty_ready_c = !wrap_c;
  assign write_c      = duty.duty_valid && duty_ready_c;
  assign duty.duty_ready = duty_ready_c;

  // Per-channel compare value (phase offset only when staggering is built in).
  always_comb begin
    for (int unsigned k = 0; k < CH; k++) begin
`ifdef PWM_DAC_PHASE_STAGGER_EN
      cmp_c[k] = ctr_q + N'(64'(k) * ((64'd1 << N) / 64'(CH)));
`else
      cmp_c[k] = ctr_q;
`endif
    end
  end

  // Next-state: counter, shadow writes, commit at wrap, comparator outputs.
  always_comb begin
    ctr_d = ctr_q;
    pwm_d = '0;
    ps_d  = wrap_c;
    if (enable) begin
      ctr_d = ctr_q + N'(1);
    end
    for (int unsigned k = 0; k < CH; k++) begin
      sh_d[k]  = sh_q[k];
      act_d[k] = act_q[k];
      // Out-of-range channel numbers match no k: accepted but dropped.
      if (write_c && (32'(duty.duty_ch) == k)) begin
        sh_d[k] = duty.duty_data;
      end
      if (wrap_c) begin
        act_d[k] = sh_q[k];
      end
      pwm_d[k] = enable && (cmp_c[k] < act_q[k]);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q <= '0;
      pwm_q <= '0;
      ps_q  <= 1'b0;
      for (int unsigned k = 0; k < CH; k++) begin
        sh_q[k]  <= '0;
        act_q[k] <= '0;
      end
    end else begin
      ctr_q <= ctr_d;
      pwm_q <= pwm_d;
      ps_q  <= ps_d;
      for (int unsigned k = 0; k < CH; k++) begin
        sh_q[k]  <= sh_d[k];
        act_q[k] <= act_d[k];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
endmodule

// File: tb/tb_pwm_dac_bank.sv
// Self-checking bench for pwm_dac_bank (N=8, CH=4): per-period high-cycle
// expectations are queued when duties are written and checked at each period_start.
module tb_pwm_dac_bank;
  localparam int N   = 8;
  localparam int CH  = 4;
  localparam int PER = 256;
`ifdef PWM_DAC_PHASE_STAGGER_EN
  localparam bit STAG = 1'b1;
`else
  localparam bit STAG = 1'b0;
`endif

  typedef struct packed {
    logic [CH-1:0][8:0] cnt;
    logic [CH-1:0][8:0] first;
    logic               shape;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [CH-1:0] pwm_out;
  logic          period_start;

  pwm_dac_bank_if #(.N(N), .CH(CH)) duty ();

  pwm_dac_bank #(.N(N), .CH(CH)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .duty         (duty),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   m_ctr  = 0;
  int   pos    = 0;
  int   en_cnt = 0;
  int   hi_cnt    [CH];
  int   first_pos [CH];
  int   last_pos  [CH];
  exp_t sb_q [$];

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input int c0, input int c1, input int c2, input int c3,
                              input bit shape);
    exp_t e;
    int   c [CH];
    c = '{c0, c1, c2, c3};
    e.shape = shape;
    for (int k = 0; k < CH; k++) begin
      e.cnt[k]   = 9'(c[k]);
      e.first[k] = STAG ? 9'(((PER - k * (PER / CH)) % PER) + 1) : 9'(1);
    end
    return e;
  endfunction

  task automatic clear_acc();
    pos    = 0;
    en_cnt = 0;
    for (int k = 0; k < CH; k++) begin
      hi_cnt[k]    = 0;
      first_pos[k] = -1;
      last_pos[k]  = -1;
    end
  endtask

  task automatic close_period();
    exp_t e;
    chk("sb_nonempty", (sb_q.size() > 0) ? 1 : 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("period_len", en_cnt, PER);
      for (int k = 0; k < CH; k++) begin
        chk($sformatf("hi_cnt_ch%0d", k), hi_cnt[k], int'(e.cnt[k]));
        if (e.shape && (e.cnt[k] != 0)) begin
          chk($sformatf("first_ch%0d", k), first_pos[k], int'(e.first[k]));
          chk($sformatf("contig_ch%0d", k), last_pos[k] - first_pos[k] + 1, hi_cnt[k]);
        end
      end
    end
    clear_acc();
  endtask

  // One clock: check ready before the edge, outputs after it, accumulate highs.
  task automatic tick();
    logic exp_ps;
    logic low;
    #1;
    if (!reset) begin
      chk("duty_ready", int'(duty.duty_ready), (enable && m_ctr == PER - 1) ? 0 : 1);
    end
    exp_ps = !reset && enable && (m_ctr == PER - 1);
    low    = reset || !enable;
    if (!reset && enable) en_cnt++;
    @(posedge clk);
    #1;
    if (reset) m_ctr = 0;
    else if (enable) m_ctr = (m_ctr + 1) % PER;
    chk("period_start", int'(period_start), int'(exp_ps));
    if (low) chk("pwm_forced_low", int'(pwm_out), 0);
    pos++;
    for (int k = 0; k < CH; k++) begin
      if (pwm_out[k]) begin
        hi_cnt[k]++;
        if (first_pos[k] < 0) first_pos[k] = pos;
        last_pos[k] = pos;
      end
    end
    if (period_start) close_period();
  endtask

  task automatic run_to_ctr(input int target);
    int n;
    n = 0;
    while (m_ctr != target && n < 2 * PER) begin
      tick();
      n++;
    end
    chk("run_to_ctr", m_ctr, target);
  endtask

  task automatic write(input int ch, input int val);
    duty.duty_valid = 1'b1;
    duty.duty_ch    = 2'(ch);
    duty.duty_data  = 8'(val);
    tick();
    duty.duty_valid = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    enable          = 1'b0;
    duty.duty_valid = 1'b0;
    duty.duty_ch    = '0;
    duty.duty_data  = '0;
    clear_acc();

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      enable          = 1'($urandom_range(0, 1));
      duty.duty_valid = 1'($urandom_range(0, 1));
      duty.duty_ch    = 2'($urandom_range(0, 3));
      duty.duty_data  = 8'($urandom_range(0, 255));
      tick();
      chk("rst_pwm", int'(pwm_out), 0);
      chk("rst_ps", int'(period_start), 0);
    end
    clear_acc();
    reset           = 1'b0;
    enable          = 1'b1;
    duty.duty_valid = 1'b0;
    #1;
    chk("rst_ready", int'(duty.duty_ready), 1);

    // Period 0 shows nothing; basic duties apply from period 1.
    sb_q.push_back(mk(0, 0, 0, 0, 1'b0));
    write(0, 64);
    write(1, 0);
    write(2, 255);
    write(3, 128);
    sb_q.push_back(mk(64, 0, 255, 128, !STAG));
    run_to_ctr(0);

    // Mid-period change: current period keeps 64, next shows 200.
    run_to_ctr(100);
    write(0, 200);
    sb_q.push_back(mk(200, 0, 255, 128, 1'b0));

    // Write held across the wrap cycle stalls one cycle.
    run_to_ctr(255);
    duty.duty_valid = 1'b1;
    duty.duty_ch    = 2'(1);
    duty.duty_data  = 8'(10);
    #1;
    chk("wrap_ready", int'(duty.duty_ready), 0);
    tick();
    #1;
    chk("post_wrap_ready", int'(duty.duty_ready), 1);
    tick();
    duty.duty_valid = 1'b0;
    sb_q.push_back(mk(200, 10, 255, 128, 1'b0));
    run_to_ctr(0);

    // Enable pause at ctr=30 for 20 cycles; period still 256 enabled cycles.
    run_to_ctr(30);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("frozen_ctr_check", m_ctr, 30);
    enable = 1'b1;
    for (int k = 0; k < CH; k++) write(k, 64);
    sb_q.push_back(mk(64, 64, 64, 64, 1'b1));
    run_to_ctr(0);

    // Equal duties: edge placement per channel.
    run_to_ctr(255);
    tick();

    // Reset mid-period drops the pending shadow value.
    run_to_ctr(40);
    write(0, 99);
    run_to_ctr(80);
    reset = 1'b1;
    tick();
    chk("midrst_pwm", int'(pwm_out), 0);
    reset = 1'b0;
    sb_q.delete();
    clear_acc();
    sb_q.push_back(mk(0, 0, 0, 0, 1'b0));
    sb_q.push_back(mk(0, 0, 0, 0, 1'b0));
    run_to_ctr(255);
    tick();
    run_to_ctr(255);
    tick();

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
